piece_collision_checker: RTL and testbench
==========================================

# piece_collision_checker

Sequential legality checker that sits directly downstream of the tetromino coordinate decoder. It accepts the four block coordinates of a candidate piece placement (after a move, drop or rotate) and reads each cell from the playfield occupancy RAM, one read per cycle. It then reports whether the placement collides with settled blocks or leaves the board. The piece-control FSM uses the result to commit or reject the move.

## Interface
Parameters:
- BOARD_W, 10, playfield width in columns; legal x is 0..BOARD_W-1.
- BOARD_H, 20, visible rows; legal stored y is 0..BOARD_H-1, with y=0 the bottom row.
- HIDDEN_ROWS, 4, rows above the visible field.
  - Legal for a piece, never stored, always treated as empty.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-high; one clock; reset is asynchronous and active-high.
- req_valid, in, 1, candidate placement present.
- req_ready, out, 1, checker idle and able to accept.
- x1..x4, in, 4 each, block column coordinates. Sampled only on accept.
- y1..y4, in, 5 each, block row coordinates. Sampled only on accept.
- rd_en, out, 1, occupancy RAM read strobe.
- rd_addr, out, 8, cell address, equal to y*BOARD_W + x.
- rd_data, in, 1, cell occupied. Valid exactly one cycle after rd_en (synchronous RAM).
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, consumer takes the result.
- rsp_collide, out, 1, placement illegal: any block occupied or out of bounds.
- rsp_oob, out, 1, at least one block out of bounds.

## Operation
- FSM states: IDLE, CHECK, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture all eight coordinates, clear the flags, set index=0 and go to CHECK.
- CHECK runs 4 cycles, one per block, in order 1,2,3,4. For block i:
  - Out of bounds when x>=BOARD_W or y>=BOARD_H+HIDDEN_ROWS. This covers the wrapped values x=15 and y=31 produced by subtracting 1 at column or row 0.
  - If out of bounds, set the oob flag and do not read: rd_en=0.
  - If the block is in a hidden row (BOARD_H <= y < BOARD_H+HIDDEN_ROWS), do not read; the cell counts as empty.
  - Otherwise assert rd_en=1 and drive rd_addr = y*BOARD_W+x, computed as (y<<3)+(y<<1)+x for BOARD_W=10. Width is 8 bits; the maximum issued address is 199.
  - After index 3, go to DRAIN.
- Read-data pipeline:
  - A 1-bit register records whether a read was issued last cycle.
  - When that register is set, OR rd_data into the occupied flag.
- DRAIN lasts 1 cycle and absorbs the last read's data, then goes to RESP.
- RESP:
  - rsp_valid=1, rsp_oob=oob flag, rsp_collide=oob|occupied.
  - All three are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- req_ready=0 in every state except IDLE; req_valid outside IDLE is ignored.
- No early termination: every request takes the full CHECK sequence, even once a collision is known.
- Duplicate coordinates among the four blocks are read twice; no special handling.

## Timing
- Reset values: state IDLE, req_ready=1, rd_en=0, rd_addr=0, rsp_valid=0, rsp_collide=0, rsp_oob=0, and all internal flags and the pipeline register cleared.
- Accept edge = T:
  - rd_en for blocks 1..4 in cycles T+1..T+4.
  - DRAIN in T+5.
  - rsp_valid rises in cycle T+6.
- With rsp_ready held high, the response lasts 1 cycle and req_ready returns in T+7.
- Throughput: one request per 7 cycles at best.
- rd_en and rd_addr are registered outputs.
- rd_addr holds its last value when rd_en=0.
- Reset mid-operation returns immediately to IDLE with reset outputs.
  - RAM data still in flight is discarded; the pipeline register is cleared.
  - No rsp_valid is produced for the aborted request.

## Test plan
- Empty board. Request (4,0),(4,1),(5,1),(5,0).
  - Required: rd_addr sequence 4,14,15,5 on T+1..T+4.
  - rsp_valid at T+6 with collide=0, oob=0.
- Cell 15 occupied, same request.
  - Required: collide=1, oob=0.
  - Cell 5 occupied instead, i.e. the last read: collide=1, checking that DRAIN captures it.
- Block with x=15 (wrapped left at column 0), others legal.
  - Required: only 3 rd_en pulses, oob=1, collide=1.
  - Repeat with y=31: same result.
- Block at y=21 (hidden), board full at every visible cell not used by the piece.
  - Required: no read for that block, collide=0, oob=0.
- rsp_ready held low 3 cycles after rsp_valid, with req_valid asserted throughout.
  - Required: outputs stable, req_ready=0, no new accept.
  - After rsp_ready: req_ready=1 next cycle and the new request is accepted.
- reset asserted at T+3.
  - Required: rd_en=0 and rsp_valid=0 immediately.
  - After release: req_ready=1, and the next request completes normally with the correct result.

Source files
------------

// File: rtl/piece_collision_checker.sv
// Sequential legality check of a four-block piece placement against the playfield
// occupancy RAM: one cell read per cycle, then a held collide/out-of-bounds result.
module piece_collision_checker #(
    parameter int unsigned BOARD_W     = 10,
    parameter int unsigned BOARD_H     = 20,
    parameter int unsigned HIDDEN_ROWS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    input  logic [3:0] x3,
    input  logic [3:0] x4,
    input  logic [4:0] y1,
    input  logic [4:0] y2,
    input  logic [4:0] y3,
    input  logic [4:0] y4,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic       rd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_collide,
    output logic       rsp_oob
);

    localparam int unsigned X_W    = 4;
    localparam int unsigned Y_W    = 5;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned N_BLK  = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DRAIN,
        RESP
    } state_t;

    state_t              state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [X_W-1:0]      x_q [N_BLK];
    logic [X_W-1:0]      x_n [N_BLK];
    logic [Y_W-1:0]      y_q [N_BLK];
    logic [Y_W-1:0]      y_n [N_BLK];
    logic                oob_q, oob_n;
    logic                occ_q, occ_n;
    logic                pend_q;

    logic                req_ready_n;
    logic                rd_en_n;
    logic [ADDR_W-1:0]   rd_addr_n;
    logic                rsp_valid_n;
    logic                rsp_collide_n;
    logic                rsp_oob_n;

    logic [X_W-1:0]      x_sel;
    logic [Y_W-1:0]      y_sel;
    logic                blk_oob;
    logic                blk_hidden;
    logic                issue;

    // Next-state and next-output logic; read strobe is computed for the block
    // that will be current next cycle so the registered rd_en lands on time.
    always_comb begin
        state_n       = state_q;
        idx_n         = idx_q;
        x_n           = x_q;
        y_n           = y_q;
        oob_n         = oob_q;
        occ_n         = occ_q | (pend_q & rd_data);
        req_ready_n   = 1'b0;
        rd_en_n       = 1'b0;
        rd_addr_n     = rd_addr;
        rsp_valid_n   = 1'b0;
        rsp_collide_n = 1'b0;
        rsp_oob_n     = 1'b0;
        x_sel         = '0;
        y_sel         = '0;
        blk_oob       = 1'b0;
        blk_hidden    = 1'b0;
        issue         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_n = CHECK;
                    idx_n   = '0;
                    x_n     = '{x1, x2, x3, x4};
                    y_n     = '{y1, y2, y3, y4};
                    oob_n   = 1'b0;
                    occ_n   = 1'b0;
                end
            end
            CHECK: begin
                if (idx_q == IDX_W'(N_BLK - 1)) begin
                    state_n = DRAIN;
                end else begin
                    idx_n = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Wrapped coordinates (x=15, y=31) fall out of range here as well.
        issue      = (state_n == CHECK);
        x_sel      = x_n[idx_n];
        y_sel      = y_n[idx_n];
        blk_oob    = (32'(x_sel) >= BOARD_W) || (32'(y_sel) >= BOARD_H + HIDDEN_ROWS);
        blk_hidden = !blk_oob && (32'(y_sel) >= BOARD_H);

        if (issue && blk_oob) begin
            oob_n = 1'b1;
        end
        rd_en_n = issue && !blk_oob && !blk_hidden;
        if (rd_en_n) begin
            rd_addr_n = ADDR_W'(y_sel) * ADDR_W'(BOARD_W) + ADDR_W'(x_sel);
        end

        req_ready_n   = (state_n == IDLE);
        rsp_valid_n   = (state_n == RESP);
        rsp_oob_n     = rsp_valid_n & oob_n;
        rsp_collide_n = rsp_valid_n & (oob_n | occ_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '{default: '0};
            y_q         <= '{default: '0};
            oob_q       <= 1'b0;
            occ_q       <= 1'b0;
            pend_q      <= 1'b0;
            req_ready   <= 1'b1;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rsp_valid   <= 1'b0;
            rsp_collide <= 1'b0;
            rsp_oob     <= 1'b0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            x_q         <= x_n;
            y_q         <= y_n;
            oob_q       <= oob_n;
            occ_q       <= occ_n;
            pend_q      <= rd_en;
            req_ready   <= req_ready_n;
            rd_en       <= rd_en_n;
            rd_addr     <= rd_addr_n;
            rsp_valid   <= rsp_valid_n;
            rsp_collide <= rsp_collide_n;
            rsp_oob     <= rsp_oob_n;
        end
    end

endmodule

// File: tb/tb_piece_collision_checker.sv
// Scoreboard bench for piece_collision_checker: expected reads and responses are
// queued at issue time and a forked monitor compares them as the DUT presents them.
module tb_piece_collision_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       rd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_collide;
    logic       rsp_oob;

    piece_collision_checker dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y4         (y4),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_collide(rsp_collide),
        .rsp_oob    (rsp_oob)
    );

    always #5 clk = ~clk;

    // Occupancy RAM model; returns 1 when not read so stale data would be noticed.
    bit mem [256];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 1'b1;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_addr [$];
    int exp_rsp  [$];   // {collide, oob} encoded as collide*2 + oob
    int rx [4];
    int ry [4];
    int ra [4];
    int lat;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rd_en) begin
                    if (exp_addr.size() == 0) check("unexpected_read", int'(rd_addr), -1);
                    else check("rd_addr", int'(rd_addr), exp_addr.pop_front());
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
                    else check("rsp_collide_oob", int'({rsp_collide, rsp_oob}), exp_rsp.pop_front());
                end
            end
        end
    endtask

    task automatic clear_board(input bit v);
        foreach (mem[i]) mem[i] = v;
    endtask

    // Queue expectations, present rx/ry and return #1 after the accept edge.
    task automatic start_req(input int n_rd, input int exp_c, input int exp_o, input bit hold);
        int n;
        bit acc;
        for (int i = 0; i < n_rd; i++) exp_addr.push_back(ra[i]);
        exp_rsp.push_back(exp_c * 2 + exp_o);
        x1 = 4'(rx[0]); x2 = 4'(rx[1]); x3 = 4'(rx[2]); x4 = 4'(rx[3]);
        y1 = 5'(ry[0]); y2 = 5'(ry[1]); y3 = 5'(ry[2]); y4 = 5'(ry[3]);
        req_valid = 1'b1;
        n = 0;
        do begin
            acc = req_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 50);
        #1;
        if (!acc) check("accept_timeout", 0, 1);
        if (!hold) req_valid = 1'b0;
    endtask

    // Cycles from the accept edge to rsp_valid, counting the first cycle as 1.
    task automatic wait_rsp(output int l);
        l = 1;
        while (!rsp_valid && l < 30) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    task automatic do_req(input int n_rd, input int exp_c, input int exp_o);
        start_req(n_rd, exp_c, exp_o, 1'b0);
        wait_rsp(lat);
        check("rsp_latency", lat, 6);
        @(posedge clk);
        #1;
        check("req_ready_after_rsp", int'(req_ready), 1);
        check("reads_outstanding", exp_addr.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        y1 = '0; y2 = '0; y3 = '0; y4 = '0;
        clear_board(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_collide", int'(rsp_collide), 0);
        check("reset_rsp_oob", int'(rsp_oob), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Square piece on an empty board, with first-read timing checked directly
        rx = '{4, 4, 5, 5}; ry = '{0, 1, 1, 0}; ra = '{4, 14, 15, 5};
        start_req(4, 0, 0, 1'b0);
        check("first_rd_en_t1", int'(rd_en), 1);
        check("first_rd_addr_t1", int'(rd_addr), 4);
        check("req_ready_busy", int'(req_ready), 0);
        wait_rsp(lat);
        check("rsp_latency", lat, 6);
        @(posedge clk);
        #1;
        check("req_ready_after_rsp", int'(req_ready), 1);
        check("reads_outstanding", exp_addr.size(), 0);

        // Same piece: middle cell occupied, then only the last-read cell
        mem[15] = 1'b1;
        do_req(4, 1, 0);
        mem[15] = 1'b0; mem[5] = 1'b1;
        do_req(4, 1, 0);
        mem[5] = 1'b0;

        // Wrapped left column and wrapped bottom row
        rx = '{15, 0, 1, 0}; ry = '{5, 5, 5, 6}; ra = '{50, 51, 60, 0};
        do_req(3, 1, 1);
        rx = '{3, 3, 4, 5}; ry = '{31, 0, 0, 0}; ra = '{3, 4, 5, 0};
        do_req(3, 1, 1);

        // Edge of legal range: (9,19)=199, (9,23) hidden, (10,0) out of bounds
        rx = '{9, 9, 0, 10}; ry = '{19, 23, 0, 0}; ra = '{199, 0, 0, 0};
        do_req(2, 1, 1);
        rx = '{0, 9, 8, 7}; ry = '{24, 0, 0, 0}; ra = '{9, 8, 7, 0};
        do_req(3, 1, 1);

        // Full board except the piece's own visible cells; upper blocks are hidden
        clear_board(1'b1);
        mem[184] = 1'b0; mem[194] = 1'b0;
        rx = '{4, 4, 4, 4}; ry = '{18, 19, 20, 21}; ra = '{184, 194, 0, 0};
        do_req(2, 0, 0);
        rx = '{0, 1, 2, 3}; ry = '{0, 0, 0, 0}; ra = '{0, 1, 2, 3};
        do_req(4, 1, 0);
        clear_board(1'b0);

        // Response back-pressure with req_valid held; second request queued behind it
        mem[2] = 1'b1;
        rsp_ready = 1'b0;
        rx = '{4, 4, 5, 5}; ry = '{0, 1, 1, 0}; ra = '{4, 14, 15, 5};
        start_req(4, 0, 0, 1'b1);
        rx = '{0, 1, 2, 3}; ry = '{0, 0, 0, 0}; ra = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) exp_addr.push_back(ra[i]);
        exp_rsp.push_back(2);
        x1 = 4'd0; x2 = 4'd1; x3 = 4'd2; x4 = 4'd3;
        y1 = 5'd0; y2 = 5'd0; y3 = 5'd0; y4 = 5'd0;
        wait_rsp(lat);
        check("stall_rsp_latency", lat, 6);
        for (int i = 0; i < 3; i++) begin
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_collide", int'(rsp_collide), 0);
            check("stall_rsp_oob", int'(rsp_oob), 0);
            check("stall_req_ready", int'(req_ready), 0);
            check("stall_rd_en", int'(rd_en), 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_stall_req_ready", int'(req_ready), 1);
        check("post_stall_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        check("second_accepted", int'(req_ready), 0);
        req_valid = 1'b0;
        wait_rsp(lat);
        check("second_rsp_latency", lat, 6);
        @(posedge clk);
        #1;
        check("reads_outstanding", exp_addr.size(), 0);
        mem[2] = 1'b0;

        // Reset in cycle T+3 after the first read has already hit an occupied cell
        mem[4] = 1'b1;
        rx = '{4, 4, 5, 5}; ry = '{0, 1, 1, 0}; ra = '{4, 14, 15, 5};
        start_req(4, 1, 0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_addr.delete();
        exp_rsp.delete();
        #1;
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem[4] = 1'b0;
        check("post_reset_req_ready", int'(req_ready), 1);
        do_req(4, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("final_addr_queue", exp_addr.size(), 0);
        check("final_rsp_queue", exp_rsp.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
